// File: rtl/bcd_counter_mux.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter_mux
// Description : Multi-digit up/down BCD tick counter with a time-multiplexed,
//               active-low common-anode seven-segment display.
//               Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_mux #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50_000
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              EN,
    input  logic              CLR,
    input  logic              DOWN,
    output logic [7:0]        nSEG,
    output logic [DIGITS-1:0] nAN,
    output logic              LD0,
    output logic              CARRY
);

    localparam int c_P  = CLK_HZ / TICK_HZ;
    localparam int c_PW = (c_P > 1) ? $clog2(c_P) : 1;
    localparam int c_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_PW-1:0] c_PMAX  = c_PW'(c_P - 1);
    localparam logic [c_PW-1:0] c_PHALF = c_PW'(c_P / 2);
    localparam logic [c_SW-1:0] c_SMAX  = c_SW'(SCAN_DIV - 1);
    localparam logic [c_IW-1:0] c_IMAX  = c_IW'(DIGITS - 1);

    logic [c_PW-1:0]   r_presc;
    logic [3:0]        r_digits [DIGITS];
    logic              r_ld0;
    logic              r_carry;
    logic [c_SW-1:0]   r_scan_cnt;
    logic [c_IW-1:0]   r_idx;
    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_an;

    logic              w_tick;
    logic [3:0]        w_next [DIGITS];
    logic              w_wrap;
    logic [3:0]        w_sel;
    logic [7:0]        w_seg;

    assign w_tick = EN && (r_presc == c_PMAX);

    // Ripple increment/decrement; w_wrap survives only if every digit rolled over.
    always_comb begin
        w_wrap = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_next[i] = r_digits[i];
            if (w_wrap) begin
                if (DOWN) begin
                    if (r_digits[i] == 4'd0) begin
                        w_next[i] = 4'd9;
                    end else begin
                        w_next[i] = r_digits[i] - 4'd1;
                        w_wrap    = 1'b0;
                    end
                end else begin
                    if (r_digits[i] >= 4'd9) begin
                        w_next[i] = 4'd0;
                    end else begin
                        w_next[i] = r_digits[i] + 4'd1;
                        w_wrap    = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_presc <= '0;
            r_ld0   <= 1'b0;
            r_carry <= 1'b0;
            for (int i = 0; i < DIGITS; i++) r_digits[i] <= 4'd0;
        end else begin
            r_ld0 <= (r_presc >= c_PHALF);
            if (CLR) begin
                r_presc <= '0;
                r_carry <= 1'b0;
                for (int i = 0; i < DIGITS; i++) r_digits[i] <= 4'd0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_carry <= w_wrap;
                for (int i = 0; i < DIGITS; i++) r_digits[i] <= w_next[i];
            end else begin
                r_carry <= 1'b0;
                if (EN) r_presc <= r_presc + 1'b1;
            end
        end
    end

    function automatic logic [7:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 8'hC0;
            4'd1:    f_decode = 8'hF9;
            4'd2:    f_decode = 8'hA4;
            4'd3:    f_decode = 8'hB0;
            4'd4:    f_decode = 8'h99;
            4'd5:    f_decode = 8'h92;
            4'd6:    f_decode = 8'h82;
            4'd7:    f_decode = 8'hD8;
            4'd8:    f_decode = 8'h80;
            4'd9:    f_decode = 8'h90;
            default: f_decode = 8'hFF;
        endcase
    endfunction

    assign w_sel = r_digits[r_idx];

`ifdef LEADING_ZERO_BLANK_EN
    // w_hi_zero[i]: digit i and every digit above it are zero.
    logic [DIGITS:0] w_hi_zero;
    always_comb begin
        w_hi_zero[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--)
            w_hi_zero[i] = w_hi_zero[i+1] && (r_digits[i] == 4'd0);
    end
    assign w_seg = ((r_idx != '0) && w_hi_zero[r_idx]) ? 8'hFF : f_decode(w_sel);
`else
    assign w_seg = f_decode(w_sel);
`endif

    // Display refreshes when the scan counter is at zero, so the first edge after reset shows digit 0.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_seg      <= 8'hFF;
            r_an       <= '1;
        end else begin
            if (r_scan_cnt == c_SMAX) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == c_IMAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            if (r_scan_cnt == '0) begin
                r_an  <= ~(DIGITS'(1) << r_idx);
                r_seg <= w_seg;
            end
        end
    end

    assign nSEG  = r_seg;
    assign nAN   = r_an;
    assign LD0   = r_ld0;
    assign CARRY = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_counter_mux
// Description : Randomized self-checking bench for bcd_counter_mux against an
//               arithmetic reference model (count held as a plain integer).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_mux;

    localparam int CLK_HZ   = 20;
    localparam int TICK_HZ  = 1;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 2;
    localparam int P        = CLK_HZ / TICK_HZ;
    localparam int NMOD     = 100;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              EN, CLR, DOWN;
    logic [7:0]        nSEG;
    logic [DIGITS-1:0] nAN;
    logic              LD0, CARRY;

    bcd_counter_mux #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)
    ) u_dut (
        .CLK(CLK), .nRST(nRST), .EN(EN), .CLR(CLR), .DOWN(DOWN),
        .nSEG(nSEG), .nAN(nAN), .LD0(LD0), .CARRY(CARRY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_val, m_presc, m_k, m_seg, m_an, m_ld0, m_carry;
    int dec_tab [10] = '{'hC0, 'hF9, 'hA4, 'hB0, 'h99, 'h92, 'h82, 'hD8, 'h80, 'h90};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_reset();
        m_val = 0; m_presc = 0; m_k = 0;
        m_seg = 'hFF; m_an = (1 << DIGITS) - 1; m_ld0 = 0; m_carry = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".nSEG"}, 32'(nSEG), 32'(m_seg));
        chk({tag, ".nAN"}, 32'(nAN), 32'(m_an));
        chk({tag, ".LD0"}, 32'(LD0), 32'(m_ld0));
        chk({tag, ".CARRY"}, 32'(CARRY), 32'(m_carry));
    endtask

    // One clock edge: model advances using the inputs held across the edge.
    task automatic step(input string tag);
        int idx, dig;
        @(posedge CLK);
        if (m_k % SCAN_DIV == 0) begin
            idx  = (m_k / SCAN_DIV) % DIGITS;
            dig  = (m_val / pow10(idx)) % 10;
            m_an = ~(1 << idx) & ((1 << DIGITS) - 1);
            m_seg = dec_tab[dig];
`ifdef LEADING_ZERO_BLANK_EN
            if (idx != 0 && m_val < pow10(idx)) m_seg = 'hFF;
`endif
        end
        m_k++;
        m_ld0 = (m_presc >= P / 2) ? 1 : 0;
        if (CLR) begin
            m_presc = 0; m_val = 0; m_carry = 0;
        end else if (EN && m_presc == P - 1) begin
            m_presc = 0;
            if (DOWN) begin
                m_carry = (m_val == 0) ? 1 : 0;
                m_val   = (m_val == 0) ? NMOD - 1 : m_val - 1;
            end else begin
                m_carry = (m_val == NMOD - 1) ? 1 : 0;
                m_val   = (m_val + 1) % NMOD;
            end
        end else begin
            m_carry = 0;
            if (EN) m_presc++;
        end
        @(negedge CLK);
        check_outputs(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Reset asserted between edges: outputs must clear before any clock edge.
    task automatic async_reset();
        #2 nRST = 1'b0;
        #1;
        chk("rst.nSEG", 32'(nSEG), 32'hFF);
        chk("rst.nAN", 32'(nAN), 32'((1 << DIGITS) - 1));
        chk("rst.LD0", 32'(LD0), 32'd0);
        chk("rst.CARRY", 32'(CARRY), 32'd0);
        model_reset();
        #1 nRST = 1'b1;
        step("first");
        chk("first.nAN", 32'(nAN), 32'b10);
        chk("first.nSEG", 32'(nSEG), 32'hC0);
    endtask

    initial begin
        nRST = 1'b0; EN = 1'b0; CLR = 1'b0; DOWN = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        run("idle", 5);

        // count up through 99 and wrap to 00
        EN = 1'b1; DOWN = 1'b0;
        run("up", 2037);
        async_reset();

        // down-wrap 00 -> 99
        EN = 1'b1; DOWN = 1'b1;
        run("down_wrap", 25);

        // CLR coinciding with a tick at 99
        for (int i = 0; i < P + 2 && m_presc != P - 1; i++) step("seek");
        chk("seek.val", 32'(m_val), 32'd99);
        CLR = 1'b1;
        step("clr_tick");
        chk("clr_tick.CARRY", 32'(CARRY), 32'd0);
        CLR = 1'b0;
        run("after_clr", 25);

        // borrow 10 -> 09
        CLR = 1'b1; step("clr2"); CLR = 1'b0;
        DOWN = 1'b0;
        run("to10", 10 * P);
        DOWN = 1'b1;
        run("borrow", P + 3);

        // pause mid-count
        run("pre_pause", 7);
        EN = 1'b0;
        run("pause", 50);
        EN = 1'b1;
        run("resume", 30);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            EN   = ($urandom_range(0, 9) != 0);
            CLR  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) DOWN = ~DOWN;
            step("rand");
        end
        CLR = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
